plab4_net_router_output_sched: RTL

PLAB4_NET_ROUTER_OUTPUT_SCHED -- requirements
Module: plab4_net_router_output_sched

---
 rtl/plab4_net_router_output_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/plab4_net_router_output_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : plab4_net_router_output_sched                                 |
// | Purpose  : Output-port scheduler for a ring router. It arbitrates among  |
// |            the west, terminal and east input ports with a round-robin    |
// |            pointer, tracks downstream queue credits, and registers the   |
// |            crossbar select for the output stage.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
//
// Ports
//   clk         : single clock; all state updates on the rising edge
//   reset       : asynchronous, active-low reset
//   reqs[2:0]   : requests ([2]=west, [1]=terminal, [0]=east)
//   grants[2:0] : combinational one-hot (or zero) grant, same bit mapping
//   credit_ret  : downstream router freed one queue entry this cycle
//   num_free    : registered credit count
//   out_val     : registered valid for the crossbar output stage
//   xbar_sel    : registered crossbar select (2=west, 1=terminal, 0=east)
//   credit_err  : sticky credit-overflow flag, cleared only by reset
//   num_grants  : (optional) saturating 16-bit grant counter
//
// Configuration
//   PLAB4_NET_ROUTER_OUTPUT_SCHED_STATS_EN : when defined, adds the num_grants
//   output and its counter. Absent otherwise; all other behaviour identical.
//------------------------------------------------------------------------------
module plab4_net_router_output_sched #(
  parameter int p_num_entries    = 4,
  parameter int p_num_free_nbits = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  reqs,
  output logic [2:0]                  grants,
  input  logic                        credit_ret,
  output logic [p_num_free_nbits-1:0] num_free,
  output logic                        out_val,
  output logic [1:0]                  xbar_sel,
  output logic                        credit_err
`ifdef PLAB4_NET_ROUTER_OUTPUT_SCHED_STATS_EN
  ,
  output logic [15:0]                 num_grants
`endif
);

  localparam logic [p_num_free_nbits-1:0] c_full = p_num_free_nbits'(p_num_entries);
  localparam logic [p_num_free_nbits-1:0] c_one  = p_num_free_nbits'(1);
  localparam logic [p_num_free_nbits-1:0] c_two  = p_num_free_nbits'(2);
  localparam logic [2:0]                  c_ptr_rst = 3'b100;

  logic [2:0]                  r_ptr;
  logic [p_num_free_nbits-1:0] r_num_free;
  logic                        r_out_val;
  logic [1:0]                  r_xbar_sel;
  logic                        r_credit_err;

  logic [2:0] w_elig;
  logic [2:0] w_grants;
  logic       w_any_grant;
  logic [1:0] w_grant_idx;

  // Eligibility looks only at the registered count, so a same-cycle credit
  // return never opens a slot. The terminal port needs two credits so that
  // injected traffic can never consume the last slot (bubble reservation),
  // which keeps the ring deadlock-free.
  always_comb begin
    w_elig    = 3'b000;
    w_elig[2] = reqs[2] && (r_num_free >= c_one);
    w_elig[1] = reqs[1] && (r_num_free >= c_two);
    w_elig[0] = reqs[0] && (r_num_free >= c_one);
  end

  // Search begins at the pointer bit and descends cyclically 2->1->0->2.
  always_comb begin
    w_grants = 3'b000;
    if (reset) begin
      case (r_ptr)
        3'b100: begin
          if      (w_elig[2]) w_grants = 3'b100;
          else if (w_elig[1]) w_grants = 3'b010;
          else if (w_elig[0]) w_grants = 3'b001;
        end
        3'b010: begin
          if      (w_elig[1]) w_grants = 3'b010;
          else if (w_elig[0]) w_grants = 3'b001;
          else if (w_elig[2]) w_grants = 3'b100;
        end
        default: begin
          if      (w_elig[0]) w_grants = 3'b001;
          else if (w_elig[2]) w_grants = 3'b100;
          else if (w_elig[1]) w_grants = 3'b010;
        end
      endcase
    end
  end

  assign w_any_grant = |w_grants;
  assign w_grant_idx = w_grants[2] ? 2'd2 : (w_grants[1] ? 2'd1 : 2'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr        <= c_ptr_rst;
      r_num_free   <= c_full;
      r_out_val    <= 1'b0;
      r_xbar_sel   <= 2'b00;
      r_credit_err <= 1'b0;
    end else begin
      if (w_any_grant) begin
        // Rotating the one-hot grant right puts the pointer just below the
        // winner, so the winner becomes lowest priority next time.
        r_ptr      <= {w_grants[0], w_grants[2:1]};
        r_out_val  <= 1'b1;
        r_xbar_sel <= w_grant_idx;
      end else begin
        r_out_val  <= 1'b0;
      end

      case ({w_any_grant, credit_ret})
        2'b10: r_num_free <= r_num_free - c_one;
        2'b01: begin
          // A return with every entry already free means the neighbour
          // returned a credit it never held; hold the count and flag it.
          if (r_num_free == c_full) r_credit_err <= 1'b1;
          else                      r_num_free   <= r_num_free + c_one;
        end
        default: ;
      endcase
    end
  end

`ifdef PLAB4_NET_ROUTER_OUTPUT_SCHED_STATS_EN
  logic [15:0] r_num_grants;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_num_grants <= 16'h0000;
    end else if (w_any_grant && (r_num_grants != 16'hFFFF)) begin
      r_num_grants <= r_num_grants + 16'h0001;
    end
  end

  assign num_grants = r_num_grants;
`endif

  assign grants     = w_grants;
  assign num_free   = r_num_free;
  assign out_val    = r_out_val;
  assign xbar_sel   = r_xbar_sel;
  assign credit_err = r_credit_err;

endmodule
`default_nettype wire
